// File: rtl/out_result_fifo.sv
// Show-ahead FIFO for placement results (x, y, strike).
// Tracks a sticky drop flag and a saturating total of popped strike counts.
module out_result_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    input  logic          in_valid,
    input  logic [7:0]    x_in,
    input  logic [7:0]    y_in,
    input  logic [3:0]    strike_in,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    x_out,
    output logic [7:0]    y_out,
    output logic [3:0]    strike_out,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic [15:0]   strike_total
);

    localparam int CW = AW + 1;

    logic [19:0]   mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [19:0]   head;
    logic [16:0]   sum;
    logic          push;
    logic          pop;

    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign head       = mem[rptr];
    assign x_out      = out_valid ? head[19:12] : 8'h00;
    assign y_out      = out_valid ? head[11:4]  : 8'h00;
    assign strike_out = out_valid ? head[3:0]   : 4'h0;

    assign sum = {1'b0, strike_total} + {13'b0, strike_out};

    // Storage needs no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem[wptr] <= {x_in, y_in, strike_in};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            overflow     <= 1'b0;
            strike_total <= 16'h0000;
        end else if (clr) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            overflow     <= 1'b0;
            strike_total <= 16'h0000;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr         <= rptr + AW'(1);
                strike_total <= sum[16] ? 16'hFFFF : sum[15:0];
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            // No bypass when full: a push attempt is dropped even if a pop occurs.
            if (in_valid && !in_ready) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_out_result_fifo.sv
// Directed testbench for out_result_fifo.
// Each scenario task drives stimulus and checks results inline.
module tb_out_result_fifo;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] x_in = 8'h00;
    logic [7:0] y_in = 8'h00;
    logic [3:0] strike_in = 4'h0;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] x_out;
    logic [7:0] y_out;
    logic [3:0] strike_out;
    logic [3:0] count;
    logic       overflow;
    logic [15:0] strike_total;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    out_result_fifo #(.DEPTH(8), .AW(3)) dut (
        .clk(clk), .rstn(rstn), .clr(clr),
        .in_valid(in_valid), .x_in(x_in), .y_in(y_in), .strike_in(strike_in),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .x_out(x_out), .y_out(y_out), .strike_out(strike_out),
        .count(count), .overflow(overflow), .strike_total(strike_total)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clr = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if (count !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_flags: count=%0d ov=%b ir=%b want 0 0 1", count, out_valid, in_ready);
        end
        n_cmp++;
        if (overflow !== 1'b0 || strike_total !== 16'h0 || {x_out, y_out, strike_out} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_data: of=%b tot=%h x=%h y=%h s=%h want zeros", overflow, strike_total, x_out, y_out, strike_out);
        end
        #10;
        rstn = 1'b1;
    endtask

    task automatic test_single_push();
        in_valid = 1'b1; x_in = 8'h12; y_in = 8'h34; strike_in = 4'h3; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (count !== 4'd1 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_count: count=%0d ov=%b want 1 1", count, out_valid);
        end
        n_cmp++;
        if (x_out !== 8'h12 || y_out !== 8'h34 || strike_out !== 4'h3) begin
            n_fail++;
            $display("FAIL single_data: x=%h y=%h s=%h want 12 34 3", x_out, y_out, strike_out);
        end
    endtask

    task automatic test_fill_overflow_drain();
        do_clear();
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; x_in = 8'(i); y_in = 8'(i + 16); strike_in = 4'(i);
            tick();
        end
        in_valid = 1'b0;
        n_cmp++;
        if (count !== 4'd8 || in_ready !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL full: count=%0d ir=%b of=%b want 8 0 0", count, in_ready, overflow);
        end
        in_valid = 1'b1; x_in = 8'hEE; strike_in = 4'hE;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (overflow !== 1'b1 || count !== 4'd8) begin
            n_fail++;
            $display("FAIL overflow: of=%b count=%0d want 1 8", overflow, count);
        end
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            n_cmp++;
            if (strike_out !== 4'(i) || x_out !== 8'(i) || y_out !== 8'(i + 16)) begin
                n_fail++;
                $display("FAIL drain_order[%0d]: x=%h y=%h s=%h want %h %h %h", i, x_out, y_out, strike_out, 8'(i), 8'(i + 16), 4'(i));
            end
            tick();
        end
        out_ready = 1'b0;
        n_cmp++;
        if (strike_total !== 16'd36 || count !== 4'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_total: tot=%0d count=%0d ov=%b want 36 0 0", strike_total, count, out_valid);
        end
        n_cmp++;
        if ({x_out, y_out, strike_out} !== 20'h0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_zero: x=%h y=%h s=%h of=%b want 0 0 0 1", x_out, y_out, strike_out, overflow);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (count !== 4'd0 || strike_total !== 16'd36) begin
            n_fail++;
            $display("FAIL pop_empty: count=%0d tot=%0d want 0 36", count, strike_total);
        end
    endtask

    task automatic test_back_to_back();
        int head;
        do_clear();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; x_in = 8'(i); y_in = 8'(100 + i); strike_in = 4'(i);
            tick();
        end
        head = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1; x_in = 8'(4 + k); y_in = 8'(104 + k); strike_in = 4'(4 + k);
            n_cmp++;
            if (x_out !== 8'(head) || y_out !== 8'(100 + head)) begin
                n_fail++;
                $display("FAIL b2b_order[%0d]: x=%h y=%h want %h %h", k, x_out, y_out, 8'(head), 8'(100 + head));
            end
            tick();
            head++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_cmp++;
        if (count !== 4'd4 || overflow !== 1'b0 || x_out !== 8'd20) begin
            n_fail++;
            $display("FAIL b2b_end: count=%0d of=%b x=%0d want 4 0 20", count, overflow, x_out);
        end
    endtask

    task automatic test_saturation();
        do_clear();
        in_valid = 1'b1; strike_in = 4'hF; x_in = 8'h55; y_in = 8'hAA;
        tick();
        out_ready = 1'b1;
        for (int p = 0; p < 4368; p++) tick();
        n_cmp++;
        if (strike_total !== 16'hFFF0 || count !== 4'd1) begin
            n_fail++;
            $display("FAIL sat_pre: tot=%h count=%0d want fff0 1", strike_total, count);
        end
        tick();
        n_cmp++;
        if (strike_total !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_hit: tot=%h want ffff", strike_total);
        end
        for (int p = 0; p < 5; p++) tick();
        n_cmp++;
        if (strike_total !== 16'hFFFF || count !== 4'd1) begin
            n_fail++;
            $display("FAIL sat_hold: tot=%h count=%0d want ffff 1", strike_total, count);
        end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_clear();
        do_clear();
        for (int i = 1; i <= 9; i++) begin
            in_valid = 1'b1; x_in = 8'(i); y_in = 8'h00; strike_in = 4'(i);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        out_ready = 1'b0;
        n_cmp++;
        if (count !== 4'd5 || overflow !== 1'b1 || strike_total !== 16'd6) begin
            n_fail++;
            $display("FAIL clr_setup: count=%0d of=%b tot=%0d want 5 1 6", count, overflow, strike_total);
        end
        clr = 1'b1; in_valid = 1'b1; out_ready = 1'b1; strike_in = 4'h7;
        tick();
        clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        n_cmp++;
        if (count !== 4'd0 || out_valid !== 1'b0 || overflow !== 1'b0 || strike_total !== 16'd0) begin
            n_fail++;
            $display("FAIL clr_prio: count=%0d ov=%b of=%b tot=%0d want 0 0 0 0", count, out_valid, overflow, strike_total);
        end
    endtask

    task automatic test_async_reset();
        do_clear();
        for (int i = 1; i <= 6; i++) begin
            in_valid = 1'b1; x_in = 8'(i); y_in = 8'(i); strike_in = 4'(i);
            tick();
        end
        n_cmp++;
        if (count !== 4'd6) begin
            n_fail++;
            $display("FAIL ar_setup: count=%0d want 6", count);
        end
        out_ready = 1'b1;
        #2;
        rstn = 1'b0;
        #0.5;
        n_cmp++;
        if (count !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || {x_out, y_out, strike_out} !== 20'h0) begin
            n_fail++;
            $display("FAIL ar_immediate: count=%0d ov=%b ir=%b x=%h want 0 0 1 0", count, out_valid, in_ready, x_out);
        end
        #0.5;
        rstn = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_cmp++;
        if (out_valid !== 1'b0 || count !== 4'd0 || strike_total !== 16'd0) begin
            n_fail++;
            $display("FAIL ar_after: ov=%b count=%0d tot=%0d want 0 0 0", out_valid, count, strike_total);
        end
        out_ready = 1'b0;
        in_valid = 1'b1; x_in = 8'h77; y_in = 8'h66; strike_in = 4'h5;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (count !== 4'd1 || x_out !== 8'h77 || strike_out !== 4'h5) begin
            n_fail++;
            $display("FAIL ar_repush: count=%0d x=%h s=%h want 1 77 5", count, x_out, strike_out);
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill_overflow_drain();
        test_back_to_back();
        test_saturation();
        test_clear();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/out_result_fifo.md
OUT_RESULT_FIFO -- requirements
Module: out_result_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of buffered placement results (power of 2, 2..64).
REQ-002 SHALL have parameter AW, default 3, pointer width, equal to log2(DEPTH).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rstn  input  1  asynchronous active-low reset.
REQ-005 clr  input  1  synchronous clear of buffer, flags and totals.
REQ-006 in_valid  input  1  upstream result present this cycle.
REQ-007 x_in  input  8  placement x coordinate.
REQ-008 y_in  input  8  placement y coordinate.
REQ-009 strike_in  input  4  strike count for the result.
REQ-010 in_ready  output  1  buffer can accept a result.
REQ-011 out_valid  output  1  head entry available.
REQ-012 out_ready  input  1  downstream consumes the head entry.
REQ-013 x_out, y_out  output  8 each  head entry coordinates.
REQ-014 strike_out  output  4  head entry strike count.
REQ-015 count  output  AW+1  number of stored entries, 0..DEPTH.
REQ-016 overflow  output  1  sticky flag: a result was dropped.
REQ-017 strike_total  output  16  saturating sum of strike values of popped entries.

Function
REQ-018 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-019 in_ready SHALL be 1 when count < DEPTH and 0 otherwise; there is no same-cycle bypass when full, even if a pop occurs.
REQ-020 out_valid SHALL be 1 when count > 0; show-ahead: x_out, y_out and strike_out SHALL present the oldest entry with zero added latency.
REQ-021 When count is 0, x_out, y_out and strike_out SHALL be 0.
REQ-022 A pushed entry SHALL be visible on the outputs, with out_valid high, in the cycle after the push edge; this is a one-cycle write-to-read latency.
REQ-023 Simultaneous push and pop SHALL leave count unchanged and keep FIFO order.
REQ-024 Read and write pointers SHALL be AW bits wide and SHALL wrap from DEPTH-1 to 0.
REQ-025 When in_valid is 1 and count is DEPTH, the result SHALL be dropped and overflow SHALL be set to 1. It SHALL remain 1 until clr or reset.
REQ-026 On each pop, strike_total SHALL become min(strike_total + strike_out, 16'hFFFF) and SHALL never wrap.
REQ-027 While clr is 1 it SHALL take priority over push and pop in the same cycle. It SHALL zero the pointers, count, overflow and strike_total; stored array contents need not be cleared.
REQ-028 out_ready while out_valid is 0 SHALL have no effect.
REQ-029 in_valid while in_ready is 0 SHALL not change count.

Reset
REQ-030 Asserting rstn low SHALL immediately set count=0, out_valid=0, in_ready=1, overflow=0, strike_total=0, x_out=y_out=0 and strike_out=0.
REQ-031 Reset asserted mid-operation SHALL discard all stored entries, and no pop SHALL be observed afterwards.
REQ-032 The first push SHALL be accepted on the first rising edge after rstn deasserts.

Verification
REQ-033 Reset, then push (x=8'h12, y=8'h34, strike=4'h3) with out_ready=0 -> next cycle count=1, out_valid=1, x_out=8'h12, y_out=8'h34, strike_out=4'h3.
REQ-034 Push 8 entries with strikes 1..8 while out_ready=0 -> count=8, in_ready=0. A 9th in_valid -> overflow=1, count stays 8. Then drain all entries -> entries arrive in order 1..8 and strike_total=36.
REQ-035 count=4 with in_valid=1 and out_ready=1 held for 20 cycles -> count stays 4, order preserved across pointer wrap, no overflow.
REQ-036 Preload strike_total near 16'hFFF0 by popping 4'hF entries repeatedly -> strike_total saturates at 16'hFFFF and stays there.
REQ-037 clr=1 together with in_valid=1 and out_ready=1 at count=5 -> next cycle count=0, out_valid=0, overflow=0, strike_total=0.
REQ-038 Drop rstn for 1 ns mid-burst at count=6 -> outputs reset immediately, out_valid stays 0 after release until a new push.
